// File: rtl/i2c_9557_pkg.sv
// Shared types and constants for the PCA9557 I2C master.
package i2c_9557_pkg;

    // Protocol sequencer states; each non-IDLE state occupies one 4-phase bit slot
    // (byte states occupy eight consecutive slots).
    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR_W,
        ACK1,
        REG,
        ACK2,
        WDATA,
        ACK3,
        RESTART,
        ADDR_R,
        ACK4,
        RDATA,
        MNACK,
        STOP
    } state_t;

    // Avalon word addresses
    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RDATA  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ACK_ERR = 2;

    // CMD field position of the read/write flag
    localparam int CMD_RW_BIT = 10;

    // PCA9557 internal register pointers
    localparam logic [1:0] PCA_INPUT    = 2'd0;
    localparam logic [1:0] PCA_OUTPUT   = 2'd1;
    localparam logic [1:0] PCA_POLARITY = 2'd2;
    localparam logic [1:0] PCA_CONFIG   = 2'd3;

endpackage

// File: rtl/i2c_9557_tick.sv
// Quarter-period tick generator: divides clk by CLK_DIV and counts the four
// phases of an SCL bit slot. Held at zero whenever disabled.
module i2c_9557_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [1:0]    phase_reg;

    assign tick  = en && (cnt_reg == TERM);
    assign phase = phase_reg;

    // Divider and phase counter; both restart from zero for every transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            phase_reg <= 2'd0;
        end else if (!en) begin
            cnt_reg   <= '0;
            phase_reg <= 2'd0;
        end else if (tick) begin
            cnt_reg   <= '0;
            phase_reg <= phase_reg + 2'd1;
        end else begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_9557_master.sv
// Avalon-MM controlled I2C master issuing single-register writes and reads to a
// PCA9557. SCL/SDA are open-drain: *_oe=1 pulls the line low.
module i2c_9557_master
    import i2c_9557_pkg::*;
#(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h18
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic        irq
);

    state_t      state_reg, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic        scl_oe_reg, sda_oe_reg, scl_next, sda_next;
    logic        busy_reg, done_reg, ack_err_reg, irq_en_reg, irq_reg;
    logic [7:0]  rdata_reg, cmd_wdata_reg;
    logic [1:0]  cmd_ptr_reg;
    logic        cmd_rw_reg;

    logic        tick;
    logic [1:0]  phase;
    logic        wr_en, cmd_accept;
    logic        end_of_slot, sample_pt, low_phase;
    logic        ack_fail, rdata_load, xfer_done;
    logic        unused_wdata;

    assign wr_en       = chipselect && !write_n;
    assign cmd_accept  = wr_en && (address == REG_CMD) && !busy_reg;
    assign end_of_slot = tick && (phase == 2'd3);
    assign sample_pt   = tick && (phase == 2'd2);
    assign low_phase   = (phase == 2'd0) || (phase == 2'd3);
    assign unused_wdata = ^writedata[15:11];

    assign scl_oe = scl_oe_reg;
    assign sda_oe = sda_oe_reg;
    assign irq    = irq_reg;

    i2c_9557_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (busy_reg),
        .tick    (tick),
        .phase   (phase)
    );

    // Sequencer state, byte shifter and registered open-drain enables.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            shift_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
            scl_oe_reg  <= 1'b0;
            sda_oe_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            scl_oe_reg  <= scl_next;
            sda_oe_reg  <= sda_next;
        end
    end

    // Next-state, shifting and line levels. Transitions happen on the tick that
    // ends phase 3 of a slot; SDA is sampled on the tick that ends phase 2.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        ack_fail     = 1'b0;
        rdata_load   = 1'b0;
        xfer_done    = 1'b0;
        scl_next     = low_phase;
        sda_next     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                scl_next = 1'b0;
                if (cmd_accept) state_next = START;
            end
            START, RESTART: begin
                // SCL high in phases 1-2 (START keeps it high from phase 0),
                // SDA falls in phase 2 while SCL is still high.
                scl_next = (state_reg == START) ? (phase == 2'd3) : low_phase;
                sda_next = phase[1];
                if (end_of_slot) begin
                    state_next   = (state_reg == START) ? ADDR_W : ADDR_R;
                    shift_next   = {DEV_ADDR, (state_reg == RESTART)};
                    bit_cnt_next = 3'd0;
                end
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
                sda_next = !shift_reg[7];
                if (end_of_slot) begin
                    shift_next   = {shift_reg[6:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        unique case (state_reg)
                            ADDR_W:  state_next = ACK1;
                            REG:     state_next = ACK2;
                            WDATA:   state_next = ACK3;
                            default: state_next = ACK4;
                        endcase
                    end
                end
            end
            ACK1, ACK2, ACK3, ACK4: begin
                // SDA released; a high level at the sample point is a NACK.
                if (sample_pt && sda_i) ack_fail = 1'b1;
                if (end_of_slot) begin
                    if (ack_err_reg) begin
                        state_next = STOP;
                    end else begin
                        unique case (state_reg)
                            ACK1: begin
                                state_next = REG;
                                shift_next = {6'b0, cmd_ptr_reg};
                            end
                            ACK2: begin
                                state_next = cmd_rw_reg ? RESTART : WDATA;
                                shift_next = cmd_wdata_reg;
                            end
                            ACK3:    state_next = STOP;
                            default: state_next = RDATA;
                        endcase
                    end
                end
            end
            RDATA: begin
                if (sample_pt) shift_next = {shift_reg[6:0], sda_i};
                if (end_of_slot) begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = MNACK;
                        rdata_load = 1'b1;
                    end
                end
            end
            MNACK: begin
                if (end_of_slot) state_next = STOP;
            end
            STOP: begin
                // SDA held low until phase 2, then rises while SCL is high.
                scl_next = (phase == 2'd0);
                sda_next = !phase[1];
                if (end_of_slot) begin
                    state_next = IDLE;
                    xfer_done  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                scl_next   = 1'b0;
            end
        endcase
    end

    // CPU-visible registers; completion sets done after a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ack_err_reg   <= 1'b0;
            rdata_reg     <= 8'h00;
            irq_en_reg    <= 1'b0;
            cmd_wdata_reg <= 8'h00;
            cmd_ptr_reg   <= 2'd0;
            cmd_rw_reg    <= 1'b0;
        end else begin
            if (cmd_accept) begin
                busy_reg      <= 1'b1;
                done_reg      <= 1'b0;
                ack_err_reg   <= 1'b0;
                cmd_wdata_reg <= writedata[7:0];
                cmd_ptr_reg   <= writedata[9:8];
                cmd_rw_reg    <= writedata[CMD_RW_BIT];
            end
            if (wr_en && (address == REG_STATUS) && writedata[STAT_DONE]) done_reg <= 1'b0;
            if (wr_en && (address == REG_CTRL)) irq_en_reg <= writedata[0];
            if (ack_fail) ack_err_reg <= 1'b1;
            if (rdata_load) rdata_reg <= shift_reg;
            if (xfer_done) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

    // Level interrupt, registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_reg <= 1'b0;
        else          irq_reg <= done_reg & irq_en_reg;
    end

    // Zero-wait-state read mux; unused bits read as zero.
    always_comb begin
        readdata = 16'h0000;
        unique case (address)
            REG_STATUS: begin
                readdata[STAT_BUSY]    = busy_reg;
                readdata[STAT_DONE]    = done_reg;
                readdata[STAT_ACK_ERR] = ack_err_reg;
            end
            REG_RDATA: readdata[7:0] = rdata_reg;
            REG_CTRL:  readdata[0]   = irq_en_reg;
            default:   readdata      = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_i2c_9557_master.sv
// Bench for i2c_9557_master: a bus-level PCA9557 slave model on the wired-AND
// lines, a register-access vector table, a transaction table and a few
// hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_i2c_9557_master;
    import i2c_9557_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int SLOT    = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'h0000;
    logic [15:0] readdata;
    logic        scl_oe, sda_oe, sda_i, irq;

    logic slave_drive = 1'b0;
    logic scl_line, sda_line;
    assign scl_line = ~scl_oe;
    assign sda_line = ~sda_oe & ~slave_drive;
    assign sda_i    = sda_line;

    int checks = 0;
    int errors = 0;

    i2c_9557_master #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'h18)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_i      (sda_i),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    bit         nack_addr = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] rx_q[$];
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         mnack_cnt = 0;
    int         cnt = 0;
    bit         in_frame = 1'b0, first_byte = 1'b0, slave_tx = 1'b0, tx_pending = 1'b0;
    logic [7:0] rx_shift = 8'h00;
    logic       scl_q = 1'b1, sda_q = 1'b1;

    always @(negedge clk) begin
        logic s, d;
        s = scl_line;
        d = sda_line;
        if (!reset_n) begin
            in_frame = 1'b0; cnt = 0; slave_drive = 1'b0; slave_tx = 1'b0;
            tx_pending = 1'b0; first_byte = 1'b0;
            s = 1'b1; d = 1'b1;
        end else if (s && scl_q && sda_q && !d) begin
            in_frame = 1'b1; cnt = 0; first_byte = 1'b1; slave_tx = 1'b0;
            start_cnt++;
        end else if (s && scl_q && !sda_q && d) begin
            in_frame = 1'b0; slave_drive = 1'b0;
            stop_cnt++;
        end else if (in_frame && !scl_q && s) begin
            cnt++;
            if (cnt <= 8 && !slave_tx) rx_shift = {rx_shift[6:0], d};
            if (cnt == 9 && slave_tx && d) mnack_cnt++;
        end else if (in_frame && scl_q && !s) begin
            if (cnt == 8) begin
                if (slave_tx) begin
                    slave_drive = 1'b0;
                end else begin
                    rx_q.push_back(rx_shift);
                    slave_drive = !(first_byte && nack_addr);
                    if (first_byte && rx_shift[0] && !nack_addr) tx_pending = 1'b1;
                    first_byte = 1'b0;
                end
            end else if (cnt == 9) begin
                cnt = 0; slave_drive = 1'b0; slave_tx = 1'b0;
                if (tx_pending) begin
                    tx_pending = 1'b0; slave_tx = 1'b1;
                    slave_drive = !tx_byte[7];
                end
            end else if (slave_tx && cnt >= 1 && cnt <= 7) begin
                slave_drive = !tx_byte[7-cnt];
            end
        end
        scl_q = s;
        sda_q = d;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_idle(output int cyc);
        logic [15:0] st;
        cyc = 0;
        bus_read(REG_STATUS, st);
        while (st[STAT_BUSY] && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            bus_read(REG_STATUS, st);
        end
        check("busy_clears", 32'(st[STAT_BUSY]), 32'd0);
    endtask

    typedef struct {
        logic [15:0]      cmd;
        bit               nack;
        logic [7:0]       tx;
        int               nbytes;
        logic [2:0][7:0]  bytes;   // bytes[2] is the first byte on the bus
        logic [15:0]      status;
        int               cycles;
        logic [15:0]      rdata;
        int               starts;
        int               mnacks;
    } trans_t;

    task automatic run_trans(input trans_t t);
        int b0, s0, p0, m0, cyc;
        logic [15:0] rd;
        b0 = rx_q.size(); s0 = start_cnt; p0 = stop_cnt; m0 = mnack_cnt;
        nack_addr = t.nack;
        tx_byte   = t.tx;
        bus_write(REG_CMD, t.cmd);
        wait_idle(cyc);
        check("cycles", 32'(cyc), 32'(t.cycles));
        check("nbytes", 32'(rx_q.size() - b0), 32'(t.nbytes));
        for (int i = 0; i < 3; i++) begin
            if (i < t.nbytes && (b0 + i) < rx_q.size())
                check($sformatf("byte%0d", i), 32'(rx_q[b0+i]), 32'(t.bytes[2-i]));
        end
        check("starts", 32'(start_cnt - s0), 32'(t.starts));
        @(posedge clk);
        #1;
        check("stops", 32'(stop_cnt - p0), 32'd1);
        check("master_nack", 32'(mnack_cnt - m0), 32'(t.mnacks));
        bus_read(REG_STATUS, rd);
        check("status", 32'(rd), 32'(t.status));
        bus_read(REG_RDATA, rd);
        check("rdata", 32'(rd), 32'(t.rdata));
        check("scl_idle", 32'(scl_oe), 32'd0);
        check("sda_idle", 32'(sda_oe), 32'd0);
        $display("trans cmd=0x%04h cycles=%0d bytes=%0d status=0x%0h rdata=0x%0h",
                 t.cmd, cyc, rx_q.size() - b0, readdata, rd);
    endtask

    typedef struct {
        logic [1:0]  addr;
        bit          wr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t rv[7];
    trans_t   tt[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int cyc;
        trans_t t;

        rv[0] = '{addr: REG_STATUS, wr: 1'b0, wdata: 16'h0000, exp: 16'h0000};
        rv[1] = '{addr: REG_RDATA,  wr: 1'b0, wdata: 16'h0000, exp: 16'h0000};
        rv[2] = '{addr: REG_CTRL,   wr: 1'b0, wdata: 16'h0000, exp: 16'h0000};
        rv[3] = '{addr: REG_CMD,    wr: 1'b0, wdata: 16'h0000, exp: 16'h0000};
        rv[4] = '{addr: REG_CTRL,   wr: 1'b1, wdata: 16'h0001, exp: 16'h0001};
        rv[5] = '{addr: REG_CTRL,   wr: 1'b1, wdata: 16'hFFFE, exp: 16'h0000};
        rv[6] = '{addr: REG_STATUS, wr: 1'b1, wdata: 16'h0003, exp: 16'h0000};

        tt[0] = '{cmd: {5'b0, 1'b0, PCA_OUTPUT, 8'hA5}, nack: 1'b0, tx: 8'h00, nbytes: 3,
                  bytes: {8'h30, 8'h01, 8'hA5}, status: 16'h0002, cycles: 29*SLOT,
                  rdata: 16'h0000, starts: 1, mnacks: 0};
        tt[1] = '{cmd: {5'b0, 1'b1, PCA_INPUT, 8'h00}, nack: 1'b0, tx: 8'h5C, nbytes: 3,
                  bytes: {8'h30, 8'h00, 8'h31}, status: 16'h0002, cycles: 39*SLOT,
                  rdata: 16'h005C, starts: 2, mnacks: 1};
        tt[2] = '{cmd: {5'b0, 1'b0, PCA_CONFIG, 8'h33}, nack: 1'b1, tx: 8'h00, nbytes: 1,
                  bytes: {8'h30, 8'h00, 8'h00}, status: 16'h0006, cycles: 11*SLOT,
                  rdata: 16'h005C, starts: 1, mnacks: 0};
        tt[3] = '{cmd: {5'b0, 1'b1, PCA_POLARITY, 8'hFF}, nack: 1'b0, tx: 8'hA3, nbytes: 3,
                  bytes: {8'h30, 8'h02, 8'h31}, status: 16'h0002, cycles: 39*SLOT,
                  rdata: 16'h00A3, starts: 2, mnacks: 1};

        // Reset state
        #1;
        check("reset_scl", 32'(scl_oe), 32'd0);
        check("reset_sda", 32'(sda_oe), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Register access vectors
        for (int i = 0; i < 7; i++) begin
            if (rv[i].wr) bus_write(rv[i].addr, rv[i].wdata);
            bus_read(rv[i].addr, rd);
            check($sformatf("reg_vec%0d", i), 32'(rd), 32'(rv[i].exp));
        end

        // Transaction table
        for (int i = 0; i < 4; i++) run_trans(tt[i]);

        // Second CMD while busy is ignored
        begin
            int b0, s0;
            b0 = rx_q.size(); s0 = start_cnt;
            nack_addr = 1'b0;
            bus_write(REG_CMD, 16'h01A5);
            repeat (50) @(posedge clk);
            #1;
            bus_write(REG_CMD, 16'h0233);
            bus_read(REG_STATUS, rd);
            check("status_mid_xfer", 32'(rd), 32'h0001);
            wait_idle(cyc);
            check("busy_cycles", 32'(cyc), 32'(29*SLOT - 51));
            check("busy_nbytes", 32'(rx_q.size() - b0), 32'd3);
            if (rx_q.size() >= b0 + 3) check("busy_byte2", 32'(rx_q[b0+2]), 32'h00A5);
            repeat (2*SLOT) @(posedge clk);
            #1;
            check("busy_starts", 32'(start_cnt - s0), 32'd1);
            bus_read(REG_STATUS, rd);
            check("busy_no_second", 32'(rd), 32'h0002);
            $display("trans cmd=0x01a5 second=0x0233 bytes=%0d status=0x%0h", rx_q.size() - b0, rd);
        end

        // Interrupt set on completion, cleared via STATUS write
        bus_write(REG_CTRL, 16'h0001);
        check("irq_before", 32'(irq), 32'd0);
        bus_write(REG_CMD, 16'h0312);
        wait_idle(cyc);
        @(posedge clk);
        #1;
        check("irq_set", 32'(irq), 32'd1);
        bus_write(REG_STATUS, 16'h0002);
        @(posedge clk);
        #1;
        check("irq_cleared", 32'(irq), 32'd0);
        bus_read(REG_STATUS, rd);
        check("done_cleared", 32'(rd), 32'h0000);
        $display("trans cmd=0x0312 irq sequence status=0x%0h", rd);

        // Reset in the middle of the REG byte
        bus_write(REG_CMD, 16'h01A5);
        repeat (13*SLOT) @(posedge clk);
        #1;
        bus_read(REG_STATUS, rd);
        check("pre_reset_busy", 32'(rd), 32'h0001);
        check("pre_reset_scl", 32'(scl_oe), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_scl", 32'(scl_oe), 32'd0);
        check("rst_sda", 32'(sda_oe), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        bus_read(REG_STATUS, rd);
        check("rst_status", 32'(rd), 32'h0000);
        bus_read(REG_CTRL, rd);
        check("rst_ctrl", 32'(rd), 32'h0000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        $display("trans reset mid-REG applied");
        t = '{cmd: 16'h0312, nack: 1'b0, tx: 8'h00, nbytes: 3,
              bytes: {8'h30, 8'h03, 8'h12}, status: 16'h0002, cycles: 29*SLOT,
              rdata: 16'h0000, starts: 1, mnacks: 0};
        run_trans(t);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
